// File: rtl/keccak_byte_feeder_if.sv
`default_nettype none
// ============================================================================
//  Module      : keccak_byte_feeder_if
//  Description : Byte-stream input and 32-bit word output bundle for the
//                keccak byte feeder.
//  Revision    : 1.0  initial release
// ============================================================================
interface keccak_byte_feeder_if;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_last;
    logic        s_ready;
    logic        empty_msg;
    logic [31:0] in;
    logic        in_ready;
    logic        is_last;
    logic [1:0]  byte_num;
    logic        buffer_full;
    logic        done;

    modport master (
        output s_data, s_valid, s_last, empty_msg, buffer_full,
        input  s_ready, in, in_ready, is_last, byte_num, done
    );

    modport slave (
        input  s_data, s_valid, s_last, empty_msg, buffer_full,
        output s_ready, in, in_ready, is_last, byte_num, done
    );
endinterface
`default_nettype wire

// File: rtl/keccak_byte_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : keccak_byte_feeder
//  Description : Packs a valid/ready byte stream into 32-bit words for the
//                keccak core, emitting the final partial or empty word.
//  Revision    : 1.0  initial release
// ============================================================================
module keccak_byte_feeder (
    input  wire logic            clk,
    input  wire logic            reset,
    keccak_byte_feeder_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_TAIL      = 2'd1,
        ST_DONE_WAIT = 2'd2,
        ST_DONE      = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [23:0] r_pack;
    logic [1:0]  r_count;
    logic [31:0] r_out_word;
    logic        r_out_last;
    logic [1:0]  r_out_nbytes;
    logic        r_out_valid;
    logic        r_done;

    logic        w_fire;
    logic        w_out_free;
    logic        w_accept;
    logic [31:0] w_merged;
    logic        w_load;
    logic [31:0] w_load_word;
    logic        w_load_last;
    logic [1:0]  w_load_nbytes;
    logic [23:0] w_pack_nxt;
    logic [1:0]  w_count_nxt;
    logic        w_set_done;

    assign w_fire     = r_out_valid & ~bus.buffer_full;
    assign w_out_free = ~r_out_valid | w_fire;
    assign w_accept   = bus.s_valid & bus.s_ready;

    // Incoming byte lands at slot r_count; pack bytes above it, zeros below.
    assign w_merged = {r_pack, 8'h00} | ({bus.s_data, 24'h000000} >> {r_count, 3'b000});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_load        = 1'b0;
        w_load_word   = 32'h0;
        w_load_last   = 1'b0;
        w_load_nbytes = 2'd0;
        w_pack_nxt    = r_pack;
        w_count_nxt   = r_count;
        w_set_done    = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (w_accept) begin
                    if (r_count == 2'd3) begin
                        w_load      = 1'b1;
                        w_load_word = w_merged;
                        w_pack_nxt  = 24'h0;
                        w_count_nxt = 2'd0;
                        if (bus.s_last) begin
                            w_state_nxt = ST_TAIL;
                        end
                    end else if (bus.s_last) begin
                        w_load        = 1'b1;
                        w_load_word   = w_merged;
                        w_load_last   = 1'b1;
                        w_load_nbytes = r_count + 2'd1;
                        w_pack_nxt    = 24'h0;
                        w_count_nxt   = 2'd0;
                        w_state_nxt   = ST_DONE_WAIT;
                    end else begin
                        w_pack_nxt  = w_merged[31:8];
                        w_count_nxt = r_count + 2'd1;
                    end
                end else if (bus.empty_msg && (r_count == 2'd0) && w_out_free) begin
                    w_load      = 1'b1;
                    w_load_last = 1'b1;
                    w_state_nxt = ST_DONE_WAIT;
                end
            end
            ST_TAIL: begin
                // Message length was a multiple of 4: follow with an empty last word.
                if (w_out_free) begin
                    w_load      = 1'b1;
                    w_load_last = 1'b1;
                    w_state_nxt = ST_DONE_WAIT;
                end
            end
            ST_DONE_WAIT: begin
                if (w_fire && r_out_last) begin
                    w_set_done  = 1'b1;
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_DONE;
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pack       <= 24'h0;
            r_count      <= 2'd0;
            r_out_word   <= 32'h0;
            r_out_last   <= 1'b0;
            r_out_nbytes <= 2'd0;
            r_out_valid  <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_pack  <= w_pack_nxt;
            r_count <= w_count_nxt;
            if (w_load) begin
                r_out_word   <= w_load_word;
                r_out_last   <= w_load_last;
                r_out_nbytes <= w_load_nbytes;
                r_out_valid  <= 1'b1;
            end else if (w_fire) begin
                r_out_valid  <= 1'b0;
            end
            if (w_set_done) begin
                r_done <= 1'b1;
            end
        end
    end

    assign bus.s_ready  = (r_state == ST_RUN) & w_out_free;
    assign bus.in_ready = w_fire;
    assign bus.is_last  = w_fire & r_out_last;
    assign bus.byte_num = (w_fire & r_out_last) ? r_out_nbytes : 2'd0;
    assign bus.in       = w_fire ? r_out_word : 32'h0;
    assign bus.done     = r_done;

endmodule
`default_nettype wire
